// File: rtl/fetch_trace_queue.sv
// Second-stage fetch trace queue: holds metadata for up to DEPTH outstanding
// instruction-bus fetches and hands the head group out as its in-order data returns.
module fetch_trace_queue #(
    parameter int DEPTH     = 4,
    parameter int FETCH_NUM = 4,
    parameter int VADDR_W   = 32,
    parameter int EXC_W     = 5,
    parameter int SIDE_W    = 66
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [VADDR_W-1:0]           in_vaddr,
    input  logic [FETCH_NUM-1:0]         in_enable,
    input  logic [FETCH_NUM-1:0]         in_pred_take,
    input  logic [FETCH_NUM*VADDR_W-1:0] in_pred_dest,
    input  logic [SIDE_W-1:0]            in_side,
    input  logic                         in_has_exc,
    input  logic [EXC_W-1:0]             in_exc_code,
    input  logic                         in_canceled,
    input  logic                         mmu_has_exc,
    input  logic [EXC_W-1:0]             mmu_exc_code,
    input  logic                         mmu_is_refill,
    input  logic                         cancel,
    input  logic                         inst_data_ok,
    output logic                         out_valid,
    output logic [VADDR_W-1:0]           out_vaddr,
    output logic [FETCH_NUM-1:0]         out_enable,
    output logic [FETCH_NUM-1:0]         out_pred_take,
    output logic [FETCH_NUM*VADDR_W-1:0] out_pred_dest,
    output logic [SIDE_W-1:0]            out_side,
    output logic                         out_has_exc,
    output logic [EXC_W-1:0]             out_exc_code,
    output logic                         out_is_refill,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         err_underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]             head;
    logic [PTR_W-1:0]             tail;
    logic [VADDR_W-1:0]           vaddr_q     [DEPTH];
    logic [FETCH_NUM-1:0]         enable_q    [DEPTH];
    logic [FETCH_NUM-1:0]         pred_take_q [DEPTH];
    logic [FETCH_NUM*VADDR_W-1:0] pred_dest_q [DEPTH];
    logic [SIDE_W-1:0]            side_q      [DEPTH];
    logic [EXC_W-1:0]             exc_code_q  [DEPTH];
    logic [DEPTH-1:0]             has_exc_q;
    logic [DEPTH-1:0]             is_refill_q;
    logic [DEPTH-1:0]             cancel_q;

    logic empty;
    logic full;
    logic push;
    logic pop;
    logic             merged_has_exc;
    logic [EXC_W-1:0] merged_exc_code;
    logic             merged_is_refill;

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    // A full queue still accepts when the head leaves in the same cycle.
    assign in_ready = !full || inst_data_ok;
    assign push     = in_valid && in_ready;
    assign pop      = inst_data_ok && !empty;

    // Upstream exceptions are older than the MMU check of the same group.
    assign merged_has_exc   = in_has_exc | mmu_has_exc;
    assign merged_exc_code  = in_has_exc ? in_exc_code : mmu_exc_code;
    assign merged_is_refill = !in_has_exc && mmu_is_refill;

    assign out_valid     = pop && !cancel_q[head];
    assign out_vaddr     = empty ? '0 : vaddr_q[head];
    assign out_enable    = empty ? '0 : enable_q[head];
    assign out_pred_take = empty ? '0 : pred_take_q[head];
    assign out_pred_dest = empty ? '0 : pred_dest_q[head];
    assign out_side      = empty ? '0 : side_q[head];
    assign out_has_exc   = empty ? 1'b0 : has_exc_q[head];
    assign out_exc_code  = empty ? '0 : exc_code_q[head];
    assign out_is_refill = empty ? 1'b0 : is_refill_q[head];

    always_ff @(posedge clk) begin
        if (rst) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            err_underflow <= 1'b0;
            has_exc_q     <= '0;
            is_refill_q   <= '0;
            cancel_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                vaddr_q[i]     <= '0;
                enable_q[i]    <= '0;
                pred_take_q[i] <= '0;
                pred_dest_q[i] <= '0;
                side_q[i]      <= '0;
                exc_code_q[i]  <= '0;
            end
        end else begin
            if (inst_data_ok && empty) begin
                err_underflow <= 1'b1;
            end
            // Non-resident slots may also be marked; the push below rewrites the bit.
            if (cancel && !empty) begin
                cancel_q <= '1;
            end
            if (push) begin
                vaddr_q[tail]     <= in_vaddr;
                enable_q[tail]    <= in_enable;
                pred_take_q[tail] <= in_pred_take;
                pred_dest_q[tail] <= in_pred_dest;
                side_q[tail]      <= in_side;
                has_exc_q[tail]   <= merged_has_exc;
                exc_code_q[tail]  <= merged_exc_code;
                is_refill_q[tail] <= merged_is_refill;
                cancel_q[tail]    <= in_canceled | cancel;
                tail              <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_trace_queue.sv
// Directed and randomized checks of fetch_trace_queue against a queue-based
// model of outstanding fetch groups.
module tb_fetch_trace_queue;

    localparam int DEPTH     = 4;
    localparam int FETCH_NUM = 4;
    localparam int VADDR_W   = 32;
    localparam int EXC_W     = 5;
    localparam int SIDE_W    = 66;
    localparam int CNT_W     = $clog2(DEPTH) + 1;

    logic                         clk = 1'b0;
    logic                         rst;
    logic                         in_valid;
    logic                         in_ready;
    logic [VADDR_W-1:0]           in_vaddr;
    logic [FETCH_NUM-1:0]         in_enable;
    logic [FETCH_NUM-1:0]         in_pred_take;
    logic [FETCH_NUM*VADDR_W-1:0] in_pred_dest;
    logic [SIDE_W-1:0]            in_side;
    logic                         in_has_exc;
    logic [EXC_W-1:0]             in_exc_code;
    logic                         in_canceled;
    logic                         mmu_has_exc;
    logic [EXC_W-1:0]             mmu_exc_code;
    logic                         mmu_is_refill;
    logic                         cancel;
    logic                         inst_data_ok;
    logic                         out_valid;
    logic [VADDR_W-1:0]           out_vaddr;
    logic [FETCH_NUM-1:0]         out_enable;
    logic [FETCH_NUM-1:0]         out_pred_take;
    logic [FETCH_NUM*VADDR_W-1:0] out_pred_dest;
    logic [SIDE_W-1:0]            out_side;
    logic                         out_has_exc;
    logic [EXC_W-1:0]             out_exc_code;
    logic                         out_is_refill;
    logic [CNT_W-1:0]             count;
    logic                         err_underflow;

    fetch_trace_queue #(
        .DEPTH(DEPTH), .FETCH_NUM(FETCH_NUM), .VADDR_W(VADDR_W),
        .EXC_W(EXC_W), .SIDE_W(SIDE_W)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_vaddr(in_vaddr),
        .in_enable(in_enable), .in_pred_take(in_pred_take), .in_pred_dest(in_pred_dest),
        .in_side(in_side), .in_has_exc(in_has_exc), .in_exc_code(in_exc_code),
        .in_canceled(in_canceled), .mmu_has_exc(mmu_has_exc), .mmu_exc_code(mmu_exc_code),
        .mmu_is_refill(mmu_is_refill), .cancel(cancel), .inst_data_ok(inst_data_ok),
        .out_valid(out_valid), .out_vaddr(out_vaddr), .out_enable(out_enable),
        .out_pred_take(out_pred_take), .out_pred_dest(out_pred_dest), .out_side(out_side),
        .out_has_exc(out_has_exc), .out_exc_code(out_exc_code), .out_is_refill(out_is_refill),
        .count(count), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [VADDR_W-1:0]           vaddr;
        logic [FETCH_NUM-1:0]         enable;
        logic [FETCH_NUM-1:0]         take;
        logic [FETCH_NUM*VADDR_W-1:0] dest;
        logic [SIDE_W-1:0]            side;
        logic                         has_exc;
        logic [EXC_W-1:0]             code;
        logic                         refill;
        logic                         canceled;
    } grp_t;

    grp_t q[$];
    logic m_err;
    int   n_asserts = 0;
    int   n_fail    = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic exp_ready;
        exp_ready = (q.size() < DEPTH) || inst_data_ok;
        chk("in_ready", 128'(in_ready), 128'(exp_ready));
        chk("count", 128'(count), 128'(q.size()));
        chk("err_underflow", 128'(err_underflow), 128'(m_err));
        if (q.size() == 0) begin
            chk("out_valid_empty", 128'(out_valid), 128'(0));
            chk("out_fields_empty", 128'({out_vaddr, out_enable, out_pred_take, out_has_exc,
                                         out_exc_code, out_is_refill}), 128'(0));
            chk("out_dest_empty", out_pred_dest, 128'(0));
            chk("out_side_empty", 128'(out_side), 128'(0));
        end else begin
            chk("out_valid", 128'(out_valid), 128'(inst_data_ok && !q[0].canceled));
            chk("out_vaddr", 128'(out_vaddr), 128'(q[0].vaddr));
            chk("out_enable", 128'(out_enable), 128'(q[0].enable));
            chk("out_pred_take", 128'(out_pred_take), 128'(q[0].take));
            chk("out_pred_dest", out_pred_dest, q[0].dest);
            chk("out_side", 128'(out_side), 128'(q[0].side));
            chk("out_has_exc", 128'(out_has_exc), 128'(q[0].has_exc));
            chk("out_exc_code", 128'(out_exc_code), 128'(q[0].code));
            chk("out_is_refill", 128'(out_is_refill), 128'(q[0].refill));
        end
    endtask

    // Called just after the clock edge, with the inputs that were sampled still held.
    task automatic model_update();
        grp_t g;
        logic ready;
        if (rst) begin
            q.delete();
            m_err = 1'b0;
            return;
        end
        ready = (q.size() < DEPTH) || inst_data_ok;
        if (inst_data_ok) begin
            if (q.size() == 0) m_err = 1'b1;
            else void'(q.pop_front());
        end
        if (cancel) foreach (q[i]) q[i].canceled = 1'b1;
        if (in_valid && ready) begin
            g.vaddr    = in_vaddr;
            g.enable   = in_enable;
            g.take     = in_pred_take;
            g.dest     = in_pred_dest;
            g.side     = in_side;
            g.has_exc  = in_has_exc | mmu_has_exc;
            g.code     = in_has_exc ? in_exc_code : mmu_exc_code;
            g.refill   = !in_has_exc && mmu_is_refill;
            g.canceled = in_canceled | cancel;
            q.push_back(g);
        end
    endtask

    task automatic clear_inputs();
        rst = 1'b0; in_valid = 1'b0; in_vaddr = '0; in_enable = '0; in_pred_take = '0;
        in_pred_dest = '0; in_side = '0; in_has_exc = 1'b0; in_exc_code = '0;
        in_canceled = 1'b0; mmu_has_exc = 1'b0; mmu_exc_code = '0; mmu_is_refill = 1'b0;
        cancel = 1'b0; inst_data_ok = 1'b0;
    endtask

    task automatic set_group(input logic [VADDR_W-1:0] va);
        in_valid     = 1'b1;
        in_vaddr     = va;
        in_enable    = FETCH_NUM'($urandom);
        in_pred_take = FETCH_NUM'($urandom);
        for (int k = 0; k < FETCH_NUM; k++) in_pred_dest[k*VADDR_W +: VADDR_W] = $urandom;
        in_side      = SIDE_W'({$urandom, $urandom, $urandom});
    endtask

    // Inputs are set just after negedge; outputs are checked 1 time unit later.
    task automatic settle();
        #1;
        check_all();
        chk("no_push_while_blocked", 128'(in_valid && !in_ready), 128'(0));
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic step();
        settle();
        advance();
    endtask

    initial begin
        clear_inputs();
        q.delete();
        m_err = 1'b0;
        rst = 1'b1;
        advance();
        rst = 1'b1;
        settle();
        chk("reset_in_ready", 128'(in_ready), 128'(1));
        chk("reset_count", 128'(count), 128'(0));
        advance();

        // Fill four groups, then drain them in order.
        for (int i = 0; i < 4; i++) begin
            set_group(32'h1000 + 32'(i * 16));
            step();
        end
        settle();
        chk("full_count", 128'(count), 128'(4));
        chk("full_not_ready", 128'(in_ready), 128'(0));
        advance();
        for (int i = 0; i < 4; i++) begin
            inst_data_ok = 1'b1;
            settle();
            chk("drain_valid", 128'(out_valid), 128'(1));
            chk("drain_order", 128'(out_vaddr), 128'(32'h1000 + 32'(i * 16)));
            advance();
        end
        settle();
        chk("drained_count", 128'(count), 128'(0));
        advance();

        // Push into a full queue alongside a pop.
        for (int i = 0; i < 4; i++) begin
            set_group(32'h1000 + 32'(i * 16));
            step();
        end
        set_group(32'h2000);
        inst_data_ok = 1'b1;
        settle();
        chk("full_swap_ready", 128'(in_ready), 128'(1));
        chk("full_swap_head", 128'(out_vaddr), 128'(32'h1000));
        chk("full_swap_valid", 128'(out_valid), 128'(1));
        advance();
        settle();
        chk("full_swap_count", 128'(count), 128'(4));
        advance();
        for (int i = 0; i < 4; i++) begin
            inst_data_ok = 1'b1;
            settle();
            if (i == 3) chk("full_swap_last", 128'(out_vaddr), 128'(32'h2000));
            advance();
        end

        // Cancel with three resident and one same-cycle push.
        for (int i = 0; i < 3; i++) begin
            set_group(32'h3100 + 32'(i * 16));
            step();
        end
        set_group(32'h3000);
        cancel = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            inst_data_ok = 1'b1;
            settle();
            chk("cancel_drop", 128'(out_valid), 128'(0));
            advance();
        end
        set_group(32'h4000);
        step();
        inst_data_ok = 1'b1;
        settle();
        chk("after_cancel_valid", 128'(out_valid), 128'(1));
        chk("after_cancel_vaddr", 128'(out_vaddr), 128'(32'h4000));
        advance();

        // Exception merge.
        set_group(32'h5000);
        in_has_exc = 1'b1; in_exc_code = 5'd4;
        mmu_has_exc = 1'b1; mmu_exc_code = 5'd2; mmu_is_refill = 1'b1;
        step();
        set_group(32'h5010);
        mmu_has_exc = 1'b1; mmu_exc_code = 5'd2; mmu_is_refill = 1'b1;
        step();
        inst_data_ok = 1'b1;
        settle();
        chk("exc_up_code", 128'({out_has_exc, out_exc_code, out_is_refill}), 128'({1'b1, 5'd4, 1'b0}));
        advance();
        inst_data_ok = 1'b1;
        settle();
        chk("exc_mmu_code", 128'({out_has_exc, out_exc_code, out_is_refill}), 128'({1'b1, 5'd2, 1'b1}));
        advance();

        // Underflow is sticky until reset.
        inst_data_ok = 1'b1;
        settle();
        chk("underflow_no_valid", 128'(out_valid), 128'(0));
        advance();
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("underflow_sticky", 128'(err_underflow), 128'(1));
            advance();
        end

        // Push on empty with same-cycle data_ok pops nothing.
        set_group(32'h6000);
        inst_data_ok = 1'b1;
        settle();
        chk("empty_push_pop_valid", 128'(out_valid), 128'(0));
        advance();
        settle();
        chk("empty_push_pop_count", 128'(count), 128'(1));
        advance();

        // Ten push/pop pairs walk the pointers around the ring.
        for (int i = 0; i < 10; i++) begin
            set_group(32'h7000 + 32'(i * 16));
            inst_data_ok = 1'b1;
            settle();
            chk("wrap_order", 128'(out_vaddr), 128'((i == 0) ? 32'h6000 : 32'h7000 + 32'((i - 1) * 16)));
            advance();
        end
        for (int i = 0; i < 2; i++) begin
            set_group(32'h7a00 + 32'(i * 16));
            step();
        end
        settle();
        chk("pre_reset_count", 128'(count), 128'(3));
        advance();
        rst = 1'b1;
        step();
        settle();
        chk("post_reset_count", 128'(count), 128'(0));
        chk("post_reset_ready", 128'(in_ready), 128'(1));
        chk("post_reset_vaddr", 128'(out_vaddr), 128'(0));
        chk("post_reset_err", 128'(err_underflow), 128'(0));
        advance();

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            inst_data_ok = ($urandom_range(0, 99) < 45);
            cancel       = ($urandom_range(0, 99) < 8);
            if ($urandom_range(0, 99) < 60 && ((q.size() < DEPTH) || inst_data_ok)) begin
                set_group($urandom);
                in_has_exc    = ($urandom_range(0, 9) == 0);
                in_exc_code   = EXC_W'($urandom);
                mmu_has_exc   = ($urandom_range(0, 9) == 0);
                mmu_exc_code  = EXC_W'($urandom);
                mmu_is_refill = $urandom_range(0, 1) == 1;
                in_canceled   = ($urandom_range(0, 19) == 0);
            end
            if (c == 250) rst = 1'b1;
            step();
        end
        settle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_trace_queue.md
Name: fetch_trace_queue

Overview:
- Parametrised successor to the single-entry second-stage fetch trace register.
- Tracks up to DEPTH outstanding instruction-bus fetch requests in issue order.
- Carries per-group metadata (VAddr, enables, prediction, exception) until the in-order inst_data_ok response returns.
- Sits between the first-stage fetch register and the instruction buffer. Supports sticky cancel of all in-flight groups on redirect/exception, and gives the IF stage a real allowin/backpressure signal.

Parameters:
- DEPTH, 4, max outstanding fetch groups (power of 2, >=2)
- FETCH_NUM, 4, instructions per fetch group
- VADDR_W, 32, virtual address width
- EXC_W, 5, exception code width
- SIDE_W, 66, opaque BTB sideband (fifthVAddr, validDest, validTake, needDelaySlot)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  fetch request accepted by bus this cycle
- in_ready  out  1  queue can accept a group
- in_vaddr  in  VADDR_W  group start VAddr
- in_enable  in  FETCH_NUM  per-slot fetch enable
- in_pred_take  in  FETCH_NUM  per-slot predicted taken
- in_pred_dest  in  FETCH_NUM*VADDR_W  per-slot predicted target
- in_side  in  SIDE_W  BTB sideband
- in_has_exc  in  1  upstream exception
- in_exc_code  in  EXC_W  upstream code
- in_canceled  in  1  group already cancelled upstream
- mmu_has_exc  in  1  MMU exception for in_vaddr
- mmu_exc_code  in  EXC_W  MMU code
- mmu_is_refill  in  1  MMU TLB refill
- cancel  in  1  OR of branch-mismatch, CP0 exception, backend flush
- inst_data_ok  in  1  bus returns head group's data
- out_valid  out  1  head response usable downstream
- out_vaddr / out_enable / out_pred_take / out_pred_dest / out_side  out  (as inputs)  head metadata
- out_has_exc  out  1  head exception
- out_exc_code  out  EXC_W  head exception code
- out_is_refill  out  1  head refill
- count  out  clog2(DEPTH)+1  occupancy
- err_underflow  out  1  sticky: inst_data_ok while empty

Behaviour:
- Storage: circular buffer with head/tail pointers of clog2(DEPTH) bits, wrap modulo DEPTH; count register tracks occupancy.
- Push when in_valid && in_ready. Pop when inst_data_ok && count!=0.
- in_ready = (count<DEPTH) || inst_data_ok. Push while full is allowed only with a same-cycle pop.
- in_valid while !in_ready: request dropped, no state change. The upstream stage must never do this; the bench flags it.
- Count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Exception merge at push:
  - has_exc = in_has_exc | mmu_has_exc
  - exc_code = in_has_exc ? in_exc_code : mmu_exc_code
  - is_refill = !in_has_exc & mmu_is_refill
- Cancel bit at push = in_canceled | cancel. A group pushed in the same cycle as cancel is cancelled.
- cancel with count!=0 sets the cancel bit of every resident entry. The bit is sticky until the entry pops.
- An entry popping in the cancel cycle uses its pre-cancel bit; out_valid is evaluated before the update.
- out_valid = inst_data_ok && count!=0 && !cancel_bit[head]. Combinational, zero added latency.
- out_* fields are combinational reads of entry[head]; all zero when count==0.
- Latency: a group pushed in cycle N is poppable from cycle N+1. A same-cycle push+data_ok on an empty queue pops nothing.
- inst_data_ok with count==0: ignored; err_underflow set and held until reset.
- Reset (rst=1 at posedge) has priority over everything: head=tail=0, count=0, all cancel bits 0, entry payloads 0, err_underflow 0. Any outstanding response is forgotten, so the system flushes the bus alongside rst.
- Reset values of outputs: in_ready=1, out_valid=0, all out_* 0, count=0, err_underflow=0.

Test Plan:
- Reset, then push 4 groups (vaddr 0x1000,0x1010,0x1020,0x1030), no data_ok -> count=4, in_ready=0; then data_ok x4 -> out_valid=1 and out_vaddr in push order, count returns 0.
- Full (count=4) with push 0x2000 and data_ok in the same cycle -> head 0x1000 popped valid, count stays 4, 0x2000 is last out.
- 3 groups resident, cancel pulse with push of 0x3000 -> all four later pop with out_valid=0. Next push 0x4000 pops with out_valid=1.
- Push with in_has_exc=1, code 4, mmu_has_exc=1, code 2, refill=1 -> out_has_exc=1, code 4, refill=0. Push with mmu exc only (code 2, refill=1) -> code 2, refill=1.
- data_ok on empty queue -> out_valid=0, err_underflow=1 and remains 1 until rst.
- Pointer wrap: 10 push/pop pairs on DEPTH=4 -> FIFO order preserved; rst asserted mid-stream with count=3 -> next cycle count=0, in_ready=1, out_* zero.
